instr_fetch_unit: RTL and testbench

- Producer side of the instruction stream consumed by the control unit and decoder. Generates sequential PCs and issues word requests to instruction memory.
- Buffers returned instruction words in an in-order FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (taken branch, JAL, JALR) driven by the control unit's PC-select decision. In-flight and buffered wrong-path words are discarded.

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to IMEM, buffers the
// returned words in an in-order FIFO for decode, and squashes wrong-path work on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_vld,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_rdy,
  output logic        o_fetch_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {ST_FETCH, ST_ERR} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  state_t          state_q, state_d;
  logic            started_q;
  logic            fetch_err_q, fetch_err_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_eff_c, disc_eff_c;
  logic [CW:0]     credit_c;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   ar_ptr_q, ar_ptr_d, aw_ptr_q, aw_ptr_d;
  logic            req_c, hs_c, push_c, pop_c;
  fetch_entry_t    push_entry_c;
  fetch_entry_t    fifo_mem [DEPTH];
  logic [31:0]     addr_mem [DEPTH];

  // Credit covers both in-flight requests and buffered words so the FIFO cannot overflow.
  assign credit_c    = {1'b0, outst_q} + {1'b0, count_q};
  assign req_c       = started_q && (state_q == ST_FETCH) && !i_redirect &&
                       (credit_c < (CW+1)'(DEPTH));
  assign o_imem_req  = req_c;
  assign o_imem_addr = fetch_pc_q;
  assign o_instr_vld = (state_q == ST_FETCH) && (count_q != '0);
  assign o_instr     = fifo_mem[rd_ptr_q].instr;
  assign o_instr_pc  = fifo_mem[rd_ptr_q].pc;
  assign o_fetch_err = fetch_err_q;

  always_comb begin
    state_d      = state_q;
    fetch_err_d  = fetch_err_q;
    fetch_pc_d   = fetch_pc_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    ar_ptr_d     = ar_ptr_q;
    aw_ptr_d     = aw_ptr_q;
    outst_eff_c  = outst_q;
    disc_eff_c   = discard_q;
    hs_c         = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    push_entry_c = '{instr: i_imem_rdata, pc: addr_mem[ar_ptr_q]};

    if (state_q == ST_FETCH) begin
      hs_c  = req_c & i_imem_gnt;
      pop_c = o_instr_vld & i_instr_rdy;
      if (i_redirect) begin
        // A response landing in the redirect cycle is wrong-path and is consumed here.
        if (i_imem_rvalid) begin
          if (discard_q != '0)    disc_eff_c  = discard_q - CW'(1);
          else if (outst_q != '0) outst_eff_c = outst_q - CW'(1);
        end
        if (i_redirect_pc[1:0] == 2'b00) begin
          fetch_pc_d = i_redirect_pc;
          discard_d  = disc_eff_c + outst_eff_c;
        end else begin
          state_d     = ST_ERR;
          fetch_err_d = 1'b1;
          discard_d   = '0;
        end
        outst_d  = '0;
        count_d  = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        ar_ptr_d = '0;
        aw_ptr_d = '0;
      end else begin
        if (i_imem_rvalid) begin
          if (discard_q != '0)    discard_d = discard_q - CW'(1);
          else if (outst_q != '0) push_c    = 1'b1;
        end
        if (hs_c) fetch_pc_d = fetch_pc_q + 32'd4;
        outst_d  = outst_q + CW'(hs_c) - CW'(push_c);
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        aw_ptr_d = aw_ptr_q + PW'(hs_c);
        ar_ptr_d = ar_ptr_q + PW'(push_c);
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_FETCH;
      started_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      outst_q     <= '0;
      discard_q   <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      ar_ptr_q    <= '0;
      aw_ptr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem[PW'(i)] <= '0;
        addr_mem[PW'(i)] <= '0;
      end
    end else begin
      state_q     <= state_d;
      started_q   <= 1'b1;
      fetch_err_q <= fetch_err_d;
      fetch_pc_q  <= fetch_pc_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      ar_ptr_q    <= ar_ptr_d;
      aw_ptr_q    <= aw_ptr_d;
      if (hs_c)   addr_mem[aw_ptr_q] <= fetch_pc_q;
      if (push_c) fifo_mem[wr_ptr_q] <= push_entry_c;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order IMEM model with tagged
// requests, and a scoreboard of expected {pc, word} pairs for decode.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_instr_vld;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_rdy = 1'b0;
  logic        o_fetch_err;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instr_vld(o_instr_vld), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_rdy(i_instr_rdy), .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] glog[$];
  logic [31:0] popped_q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  logic [31:0] model_pc = RESET_PC;
  bit          model_err = 1'b0;
  bit          gnt_rand = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rdy_mode = 1'b1;
  bit          redir_pend = 1'b0;
  logic [31:0] redir_tgt = '0;
  bit          last_pop, last_rvalid;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock of environment + scoreboard; inputs change and outputs are sampled mid low phase.
  task automatic step();
    int   outs;
    bit   rdy, exp_req, exp_vld;
    @(negedge i_clk);
    i_redirect    = redir_pend;
    i_redirect_pc = redir_tgt;
    redir_pend    = 1'b0;
    rdy           = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_mode;
    i_instr_rdy   = rdy;
    i_imem_gnt    = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    outs = 0;
    foreach (pend_q[k]) if (pend_q[k].epoch == epoch) outs++;
    exp_req = !model_err && !i_redirect && ((outs + exp_q.size()) < DEPTH);
    exp_vld = !model_err && (exp_q.size() > 0);

    total++;
    if (o_imem_req !== exp_req) begin
      bad++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, o_imem_req, exp_req);
    end
    total++;
    if (o_instr_vld !== exp_vld) begin
      bad++; $display("FAIL instr_vld cyc=%0d got=%b exp=%b", cyc, o_instr_vld, exp_vld);
    end
    total++;
    if (o_fetch_err !== model_err) begin
      bad++; $display("FAIL fetch_err cyc=%0d got=%b exp=%b", cyc, o_fetch_err, model_err);
    end
    if (exp_req) begin
      total++;
      if (o_imem_addr !== model_pc) begin
        bad++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, o_imem_addr, model_pc);
      end
    end
    if (o_instr_vld && exp_q.size() > 0) begin
      total++;
      if (o_instr !== exp_q[0].data || o_instr_pc !== exp_q[0].pc) begin
        bad++;
        $display("FAIL instr_head cyc=%0d got=%h@%h exp=%h@%h", cyc, o_instr, o_instr_pc,
                 exp_q[0].data, exp_q[0].pc);
      end
    end

    last_pop = o_instr_vld && rdy;
    if (last_pop) begin
      last_pop_pc = o_instr_pc;
      popped_q.push_back(o_instr_pc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end

    if (i_redirect && !model_err) begin
      if (i_redirect_pc[1:0] == 2'b00) begin
        epoch++;
        exp_q.delete();
        model_pc = i_redirect_pc;
      end else begin
        model_err = 1'b1;
        exp_q.delete();
        pend_q.delete();
      end
    end

    if (o_imem_req && i_imem_gnt) glog.push_back(o_imem_addr);
    if (exp_req && i_imem_gnt) begin
      pend_q.push_back('{addr: model_pc, data: mem_data(model_pc), epoch: epoch, due: cyc + lat});
      model_pc = model_pc + 32'd4;
    end

    if (!model_err && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = pend_q[0].data;
      if (pend_q[0].epoch == epoch) exp_q.push_back('{pc: pend_q[0].addr, data: pend_q[0].data});
      void'(pend_q.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    last_rvalid = i_imem_rvalid;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse placed away from clock edges; outputs checked while held.
  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_imem_req !== 1'b0 || o_instr_vld !== 1'b0 || o_fetch_err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got req=%b vld=%b err=%b exp=0/0/0",
                      o_imem_req, o_instr_vld, o_fetch_err);
    end
    total++;
    if (o_imem_addr !== RESET_PC || o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin
      bad++; $display("FAIL reset_data got addr=%h instr=%h pc=%h exp=%h/0/0",
                      o_imem_addr, o_instr, o_instr_pc, RESET_PC);
    end
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_redirect = 1'b0; i_instr_rdy = 1'b0;
    pend_q.delete(); exp_q.delete(); glog.delete(); popped_q.delete();
    model_pc = RESET_PC; model_err = 1'b0; redir_pend = 1'b0; epoch++;
    gnt_rand = 1'b0; rdy_rand = 1'b0; rdy_mode = 1'b1; lat = 1;
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    run(12);
    total++;
    if (glog.size() < 3 || glog[0] !== 32'h0 || glog[1] !== 32'h4 || glog[2] !== 32'h8) begin
      bad++; $display("FAIL stream_addr got n=%0d first=%h exp=0,4,8", glog.size(),
                      glog.size() > 0 ? glog[0] : 32'hx);
    end
    total++;
    if (popped_q.size() < 2 || popped_q[0] !== 32'h0 || popped_q[1] !== 32'h4) begin
      bad++; $display("FAIL stream_pc got n=%0d exp>=2 starting 0,4", popped_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 1'b0;
    run(10);
    total++;
    if (glog.size() != DEPTH) begin
      bad++; $display("FAIL bp_grants got=%0d exp=%0d", glog.size(), DEPTH);
    end
    total++;
    if (o_imem_req !== 1'b0) begin
      bad++; $display("FAIL bp_req_low got=%b exp=0", o_imem_req);
    end
    rdy_mode = 1'b1;
    run(10);
    total++;
    if (popped_q.size() < 4 || popped_q[0] !== 32'h0 || popped_q[1] !== 32'h4 ||
        popped_q[2] !== 32'h8 || popped_q[3] !== 32'hC) begin
      bad++; $display("FAIL bp_drain_order got n=%0d exp 0,4,8,c", popped_q.size());
    end
    total++;
    if (glog.size() < 5 || glog[4] !== 32'h10) begin
      bad++; $display("FAIL bp_resume got n=%0d addr=%h exp=00000010", glog.size(),
                      glog.size() > 4 ? glog[4] : 32'hx);
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    lat = 4;
    redir_pend = 1'b1; redir_tgt = 32'h20;
    step();
    for (int i = 0; i < 20 && glog.size() < 3; i++) step();
    total++;
    if (glog.size() != 3) begin
      bad++; $display("FAIL flush_setup got grants=%0d exp=3", glog.size());
    end
    popped_q.delete();
    redir_pend = 1'b1; redir_tgt = 32'h100;
    run(16);
    total++;
    if (popped_q.size() == 0 || popped_q[0] !== 32'h100) begin
      bad++; $display("FAIL flush_first_pc got=%h exp=00000100",
                      popped_q.size() > 0 ? popped_q[0] : 32'hx);
    end
    foreach (popped_q[k]) begin
      if (popped_q[k] >= 32'h20 && popped_q[k] <= 32'h2C) begin
        total++; bad++;
        $display("FAIL flush_leak got pc=%h exp outside 20..2c", popped_q[k]);
      end
    end
  endtask

  task automatic test_redirect_pop_rvalid();
    int          seen;
    logic [31:0] ppc;
    do_reset();
    run(8);
    glog.delete();
    redir_pend = 1'b1; redir_tgt = 32'h200;
    step();
    ppc = last_pop_pc;
    total++;
    if (!(last_pop && last_rvalid)) begin
      bad++; $display("FAIL coincide got pop=%b rvalid=%b exp=1/1", last_pop, last_rvalid);
    end
    run(8);
    seen = 0;
    foreach (popped_q[k]) if (popped_q[k] === ppc) seen++;
    total++;
    if (seen != 1) begin
      bad++; $display("FAIL coincide_once got=%0d exp=1 pc=%h", seen, ppc);
    end
    total++;
    if (glog.size() == 0 || glog[0] !== 32'h200) begin
      bad++; $display("FAIL coincide_target got=%h exp=00000200",
                      glog.size() > 0 ? glog[0] : 32'hx);
    end
  endtask

  task automatic test_error();
    do_reset();
    run(3);
    redir_pend = 1'b1; redir_tgt = 32'h102;
    step();
    step();
    total++;
    if (o_fetch_err !== 1'b1 || o_imem_req !== 1'b0 || o_instr_vld !== 1'b0) begin
      bad++; $display("FAIL err_enter got err=%b req=%b vld=%b exp=1/0/0",
                      o_fetch_err, o_imem_req, o_instr_vld);
    end
    redir_pend = 1'b1; redir_tgt = 32'h300;
    run(5);
    do_reset();
    run(4);
    total++;
    if (glog.size() == 0 || glog[0] !== RESET_PC) begin
      bad++; $display("FAIL err_restart got=%h exp=%h", glog.size() > 0 ? glog[0] : 32'hx,
                      RESET_PC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redir_pend = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    run(10);
    total++;
    if (glog.size() < 4 || glog[0] !== 32'hFFFF_FFF8 || glog[1] !== 32'hFFFF_FFFC ||
        glog[2] !== 32'h0 || glog[3] !== 32'h4) begin
      bad++; $display("FAIL wrap got n=%0d third=%h exp fff..f8,fff..fc,0,4", glog.size(),
                      glog.size() > 2 ? glog[2] : 32'hx);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat = 2; gnt_rand = 1'b1; rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        redir_pend = 1'b1;
        redir_tgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      step();
    end
    gnt_rand = 1'b0; rdy_rand = 1'b0; rdy_mode = 1'b1;
    run(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_pop_rvalid();
    test_error();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
